regex_feeder: RTL and testbench

Upstream stage of the regular-expression checker. Accepts an ASCII character stream over a valid/ready handshake, maps 'A'–'D' to 2-bit symbols, and buffers one complete string. It then resets the checker and replays the string contiguously, one symbol per clock, because the checker cannot stall. It captures the checker's done/result and reports one verdict per string, plus error flags for invalid characters, overflow and timeout.

---
 rtl/regex_feeder.sv | 165 ++++++++++++++++
 tb/tb_regex_feeder.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/regex_feeder.sv
// regex_feeder: buffers one A-D string, then resets and streams it to the
// regex checker. Returns one verdict per string with error reporting.
//
// Ports:
//   clk, res                    clock, synchronous active-high reset
//   char_in/char_valid/
//   char_last/char_ready        upstream character handshake
//   chk_res_n                   active-low checker reset
//   symbol_out/last_symbol_out  contiguous symbol stream to checker
//   chk_done/chk_result         checker completion and match result
//   str_valid/str_match/str_err one-cycle verdict per string
module regex_feeder #(
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 4
) (
  input  logic       clk,
  input  logic       res,
  input  logic [7:0] char_in,
  input  logic       char_valid,
  input  logic       char_last,
  output logic       char_ready,
  output logic       chk_res_n,
  output logic [1:0] symbol_out,
  output logic       last_symbol_out,
  input  logic       chk_done,
  input  logic       chk_result,
  output logic       str_valid,
  output logic       str_match,
  output logic       str_err
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    COLLECT,
    RESET_CHK,
    STREAM,
    WAIT_DONE,
    REPORT
  } state_t;

  state_t        state;
  logic [1:0]    mem [DEPTH];
  logic [CW-1:0] count;
  logic [CW-1:0] rd;
  logic          err;
  logic [TW-1:0] tmo;

  logic [7:0] lower;
  logic       char_ok;
  logic [1:0] sym;
  logic       full;
  logic       accept;

  // Folding bit 5 makes upper and lower case share one range check.
  always_comb begin
    lower   = char_in | 8'h20;
    char_ok = (lower >= 8'h61) && (lower <= 8'h64);
    sym     = lower[1:0] - 2'd1;
    full    = (count == CW'(DEPTH));
    accept  = char_valid && char_ready && (state == COLLECT);
  end

  always_ff @(posedge clk) begin
    if (accept && char_ok && !full) begin
      mem[count[IW-1:0]] <= sym;
    end
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state           <= COLLECT;
      char_ready      <= 1'b0;
      chk_res_n       <= 1'b0;
      symbol_out      <= 2'b00;
      last_symbol_out <= 1'b0;
      str_valid       <= 1'b0;
      str_match       <= 1'b0;
      str_err         <= 1'b0;
      count           <= '0;
      rd              <= '0;
      err             <= 1'b0;
      tmo             <= '0;
    end else begin
      str_valid <= 1'b0;
      unique case (state)
        COLLECT: begin
          char_ready <= 1'b1;
          if (accept) begin
            if (!char_ok || full) begin
              err <= 1'b1;
            end else begin
              count <= count + CW'(1);
            end
            if (char_last) begin
              char_ready <= 1'b0;
              // A bad string never reaches the checker.
              if (err || !char_ok || full) begin
                str_valid <= 1'b1;
                str_match <= 1'b0;
                str_err   <= 1'b1;
                state     <= REPORT;
              end else begin
                state <= RESET_CHK;
              end
            end
          end
        end
        RESET_CHK: begin
          symbol_out      <= mem[0];
          last_symbol_out <= (count == CW'(1));
          rd              <= CW'(1);
          chk_res_n       <= 1'b1;
          state           <= STREAM;
        end
        STREAM: begin
          if (chk_done) begin
            str_valid <= 1'b1;
            str_match <= chk_result;
            str_err   <= 1'b0;
            chk_res_n <= 1'b0;
            state     <= REPORT;
          end else if (last_symbol_out) begin
            state <= WAIT_DONE;
          end else begin
            symbol_out      <= mem[rd[IW-1:0]];
            last_symbol_out <= (rd == count - CW'(1));
            rd              <= rd + CW'(1);
          end
        end
        WAIT_DONE: begin
          if (chk_done) begin
            str_valid <= 1'b1;
            str_match <= chk_result;
            str_err   <= 1'b0;
            chk_res_n <= 1'b0;
            state     <= REPORT;
          end else if (tmo == TW'(TIMEOUT - 1)) begin
            str_valid <= 1'b1;
            str_match <= 1'b0;
            str_err   <= 1'b1;
            chk_res_n <= 1'b0;
            state     <= REPORT;
          end else begin
            tmo <= tmo + TW'(1);
          end
        end
        REPORT: begin
          count      <= '0;
          rd         <= '0;
          err        <= 1'b0;
          tmo        <= '0;
          str_match  <= 1'b0;
          str_err    <= 1'b0;
          char_ready <= 1'b1;
          state      <= COLLECT;
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_regex_feeder.sv
// Self-checking bench for regex_feeder: directed plan strings plus
// random strings against a cycle-timeline reference model.
module tb_regex_feeder;

  localparam int DEPTH   = 16;
  localparam int TIMEOUT = 4;

  typedef logic [7:0] ch_t;
  typedef ch_t chq_t[$];

  logic       clk;
  logic       res;
  logic [7:0] char_in;
  logic       char_valid;
  logic       char_last;
  logic       char_ready;
  logic       chk_res_n;
  logic [1:0] symbol_out;
  logic       last_symbol_out;
  logic       chk_done;
  logic       chk_result;
  logic       str_valid;
  logic       str_match;
  logic       str_err;

  int checks = 0;
  int errors = 0;

  regex_feeder #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk),
    .res(res),
    .char_in(char_in),
    .char_valid(char_valid),
    .char_last(char_last),
    .char_ready(char_ready),
    .chk_res_n(chk_res_n),
    .symbol_out(symbol_out),
    .last_symbol_out(last_symbol_out),
    .chk_done(chk_done),
    .chk_result(chk_result),
    .str_valid(str_valid),
    .str_match(str_match),
    .str_err(str_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit is_ok(input ch_t c);
    ch_t l;
    l = c | 8'h20;
    return (l >= 8'h61) && (l <= 8'h64);
  endfunction

  function automatic logic [1:0] sym_of(input ch_t c);
    ch_t l;
    l = (c | 8'h20) - 8'h61;
    return l[1:0];
  endfunction

  function automatic chq_t mk(input string st);
    chq_t q;
    for (int i = 0; i < st.len(); i++) q.push_back(ch_t'(st[i]));
    return q;
  endfunction

  // Returns #1 after the edge that accepted the last character.
  task automatic send_str(input chq_t s, input int gap_pct, output bit ok);
    ok = 1'b1;
    for (int i = 0; i < s.size(); i++) begin
      bit acc;
      int n;
      if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
        char_valid = 1'b0;
        tick();
      end
      char_in    = s[i];
      char_last  = (i == s.size() - 1);
      char_valid = 1'b1;
      acc = 1'b0;
      n   = 0;
      while (!acc && n < 64) begin
        acc = char_ready;
        tick();
        n++;
      end
      if (!acc) begin
        chk("accept_timeout", 8'd0, 8'd1);
        ok = 1'b0;
        break;
      end
    end
    char_valid = 1'b0;
    char_last  = 1'b0;
  endtask

  // Reference timeline: cycle k after the last accepted character.
  task automatic run_check(input chq_t s, input int done_cyc,
                           input bit rv, input string tag);
    bit         bad;
    bit         hit;
    logic [1:0] sy[$];
    int         n;
    int         r;
    bad = (s.size() > DEPTH);
    foreach (s[i]) begin
      if (!is_ok(s[i])) bad = 1'b1;
      else sy.push_back(sym_of(s[i]));
    end
    n   = sy.size();
    hit = !bad && done_cyc >= 2 && done_cyc <= n + 1 + TIMEOUT;
    r   = bad ? 1 : (hit ? done_cyc + 1 : n + 2 + TIMEOUT);
    for (int k = 1; k <= r + 1; k++) begin
      chk_done   = !bad && (k == done_cyc);
      chk_result = rv;
      if (k < r) begin
        chk($sformatf("%s.k%0d.valid", tag, k), 8'(str_valid), 8'd0);
        chk($sformatf("%s.k%0d.ready", tag, k), 8'(char_ready), 8'd0);
        chk($sformatf("%s.k%0d.res_n", tag, k), 8'(chk_res_n),
            8'(k >= 2));
        if (k >= 2) begin
          chk($sformatf("%s.k%0d.sym", tag, k), 8'(symbol_out),
              8'(k <= n + 1 ? sy[k-2] : sy[n-1]));
          chk($sformatf("%s.k%0d.last", tag, k), 8'(last_symbol_out),
              8'(k >= n + 1));
        end
      end else if (k == r) begin
        chk($sformatf("%s.verdict.valid", tag), 8'(str_valid), 8'd1);
        chk($sformatf("%s.verdict.match", tag), 8'(str_match),
            8'(hit && rv));
        chk($sformatf("%s.verdict.err", tag), 8'(str_err), 8'(!hit));
        chk($sformatf("%s.verdict.res_n", tag), 8'(chk_res_n), 8'd0);
      end else begin
        chk($sformatf("%s.after.valid", tag), 8'(str_valid), 8'd0);
        chk($sformatf("%s.after.ready", tag), 8'(char_ready), 8'd1);
        chk($sformatf("%s.after.res_n", tag), 8'(chk_res_n), 8'd0);
      end
      tick();
    end
    chk_done   = 1'b0;
    chk_result = 1'b0;
  endtask

  task automatic do_str(input chq_t s, input int done_cyc, input bit rv,
                        input int gap_pct, input string tag);
    bit ok;
    send_str(s, gap_pct, ok);
    if (ok) run_check(s, done_cyc, rv, tag);
  endtask

  initial begin
    chq_t s;
    bit   ok;
    res        = 1'b1;
    char_in    = 8'h00;
    char_valid = 1'b0;
    char_last  = 1'b0;
    chk_done   = 1'b0;
    chk_result = 1'b0;
    repeat (3) tick();
    chk("rst.ready", 8'(char_ready), 8'd0);
    chk("rst.res_n", 8'(chk_res_n), 8'd0);
    chk("rst.sym", 8'(symbol_out), 8'd0);
    chk("rst.last", 8'(last_symbol_out), 8'd0);
    chk("rst.valid", 8'(str_valid), 8'd0);
    chk("rst.match", 8'(str_match), 8'd0);
    chk("rst.err", 8'(str_err), 8'd0);
    res = 1'b0;
    tick();

    do_str(mk("ABCAD"), 7, 1'b1, 0, "abcad");
    do_str(mk("D"), 3, 1'b1, 0, "single_d");
    do_str(mk("ACD"), 4, 1'b0, 0, "acd_early");
    do_str(mk("ABxCD"), -1, 1'b0, 0, "invalid");
    do_str(mk("ABCDABCDABCDABCDA"), -1, 1'b0, 0, "overflow");
    do_str(mk("ABCDBACDABCDDCBA"), 18, 1'b1, 0, "full16");
    do_str(mk("ABCAD"), -1, 1'b1, 0, "stuck");
    do_str(mk("abcd"), 6, 1'b0, 0, "lower");

    send_str(mk("ABCAD"), 0, ok);
    tick();
    tick();
    res = 1'b1;
    tick();
    res = 1'b0;
    chk("midrst.ready", 8'(char_ready), 8'd0);
    chk("midrst.res_n", 8'(chk_res_n), 8'd0);
    chk("midrst.sym", 8'(symbol_out), 8'd0);
    chk("midrst.last", 8'(last_symbol_out), 8'd0);
    chk("midrst.valid", 8'(str_valid), 8'd0);
    chk("midrst.match", 8'(str_match), 8'd0);
    chk("midrst.err", 8'(str_err), 8'd0);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("midrst.quiet", 8'(str_valid), 8'd0);
    end
    do_str(mk("BDCA"), 6, 1'b1, 0, "post_rst");

    for (int it = 0; it < 40; it++) begin
      int len;
      s = {};
      len = $urandom_range(1, DEPTH + 2);
      for (int i = 0; i < len; i++) begin
        ch_t c;
        if ($urandom_range(15) == 0) begin
          c = 8'h41;
          while (is_ok(c)) c = 8'($urandom_range(8'h20, 8'h7e));
        end else begin
          c = ($urandom_range(1) != 0 ? 8'h41 : 8'h61)
              + 8'($urandom_range(3));
        end
        s.push_back(c);
      end
      do_str(s, $urandom_range(2, len + 7), 1'($urandom_range(1)), 25,
             $sformatf("rnd%0d", it));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
